// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller: state encoding,
// calendar field widths and field limits.
package alarm_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZED = 2'd3
    } state_e;

endpackage

// File: rtl/alarm_ctrl_if.sv
// Bundle of calendar time, user controls and alarm status between the
// alarm controller (slave) and whoever drives it (master).
interface alarm_ctrl_if;
    import alarm_pkg::*;

    logic [SEC_W-1:0]  SECOND;
    logic [MIN_W-1:0]  MINUTE;
    logic [HOUR_W-1:0] HOUR;
    logic              ARM;
    logic              SET_EN;
    logic [HOUR_W-1:0] SET_HOUR;
    logic [MIN_W-1:0]  SET_MINUTE;
    logic              STOP;
    logic              SNOOZE;
    logic              RING;
    logic [HOUR_W-1:0] ALARM_HOUR;
    logic [MIN_W-1:0]  ALARM_MINUTE;
    logic [1:0]        STATE;
    logic              SET_ERR;

    modport master (
        output SECOND, MINUTE, HOUR, ARM, SET_EN, SET_HOUR, SET_MINUTE, STOP, SNOOZE,
        input  RING, ALARM_HOUR, ALARM_MINUTE, STATE, SET_ERR
    );

    modport slave (
        input  SECOND, MINUTE, HOUR, ARM, SET_EN, SET_HOUR, SET_MINUTE, STOP, SNOOZE,
        output RING, ALARM_HOUR, ALARM_MINUTE, STATE, SET_ERR
    );

endinterface

// File: rtl/alarm_ctrl_time_add_min.sv
// Combinational HOUR:MINUTE + N_MIN minutes, wrapping minutes mod 60 and
// hours mod 24. Inputs are assumed to be legal calendar values.
module time_add_min
    import alarm_pkg::*;
#(
    parameter int N_MIN = 5
) (
    input  logic [HOUR_W-1:0] hour_i,
    input  logic [MIN_W-1:0]  min_i,
    output logic [HOUR_W-1:0] hour_o,
    output logic [MIN_W-1:0]  min_o
);

    logic [MIN_W:0]  min_sum;
    logic [MIN_W:0]  min_wrap;
    logic            carry;
    logic [HOUR_W:0] hour_sum;

    // Minute add with single carry into the hour, then day wrap on the hour.
    always_comb begin
        min_sum  = {1'b0, min_i} + 7'(N_MIN);
        carry    = (min_sum > {1'b0, MIN_MAX});
        min_wrap = carry ? (min_sum - ({1'b0, MIN_MAX} + 7'd1)) : min_sum;
        hour_sum = {1'b0, hour_i} + {{HOUR_W{1'b0}}, carry};
        min_o    = min_wrap[MIN_W-1:0];
        hour_o   = (hour_sum > {1'b0, HOUR_MAX}) ? '0 : hour_sum[HOUR_W-1:0];
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: detects second ticks from the calendar, compares the
// running time against the programmed alarm or snooze target, and runs the
// IDLE/ARMED/RINGING/SNOOZED state machine that drives RING.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5
) (
    input  logic         CLK_IN,
    input  logic         RST_N,
    alarm_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    logic [7:0]        ring_cnt_q, ring_cnt_d;
    logic [SEC_W-1:0]  sec_q;
    logic              prev_valid_q;
    logic [HOUR_W-1:0] alarm_hour_q;
    logic [MIN_W-1:0]  alarm_min_q;
    logic [HOUR_W-1:0] snz_hour_q;
    logic [MIN_W-1:0]  snz_min_q;
    logic [HOUR_W-1:0] snz_hour_calc;
    logic [MIN_W-1:0]  snz_min_calc;
    logic              ring_q;
    logic              set_err_q;
    logic              snz_load;
    logic              tick;
    logic              set_valid;
    logic              match_alarm;
    logic              match_snooze;

    time_add_min #(.N_MIN(SNOOZE_MINUTES)) u_snz_add (
        .hour_i (bus.HOUR),
        .min_i  (bus.MINUTE),
        .hour_o (snz_hour_calc),
        .min_o  (snz_min_calc)
    );

    // A tick is any change of SECOND; matches only count on a tick so a
    // frozen calendar time can never re-fire the alarm.
    assign tick         = prev_valid_q && (bus.SECOND != sec_q);
    assign match_alarm  = tick && (bus.SECOND == '0) &&
                          (bus.HOUR == alarm_hour_q) && (bus.MINUTE == alarm_min_q);
    assign match_snooze = tick && (bus.SECOND == '0) &&
                          (bus.HOUR == snz_hour_q) && (bus.MINUTE == snz_min_q);
    assign set_valid    = bus.SET_EN && (bus.SET_HOUR <= HOUR_MAX) &&
                          (bus.SET_MINUTE <= MIN_MAX);

    // Next-state logic; priority is !ARM, valid SET_EN, STOP, SNOOZE, tick/match.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_load   = 1'b0;
        if (!bus.ARM) begin
            state_d = ST_IDLE;
        end else if (set_valid) begin
            if (state_q == ST_RINGING || state_q == ST_SNOOZED) begin
                state_d = ST_ARMED;
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (match_alarm) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = '0;
                    end
                end
                ST_RINGING: begin
                    if (bus.STOP) begin
                        state_d = ST_ARMED;
                    end else if (bus.SNOOZE) begin
                        state_d  = ST_SNOOZED;
                        snz_load = 1'b1;
                    end else if (tick) begin
                        if (ring_cnt_q == 8'(RING_SECONDS - 1)) begin
                            state_d = ST_ARMED;
                        end else begin
                            ring_cnt_d = ring_cnt_q + 8'd1;
                        end
                    end
                end
                ST_SNOOZED: begin
                    if (bus.STOP) begin
                        state_d = ST_ARMED;
                    end else if (match_snooze) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, ring counter and registered status outputs.
    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
            ring_q     <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            ring_q     <= (state_d == ST_RINGING);
            set_err_q  <= bus.SET_EN && !set_valid;
        end
    end

    // Second history for tick detection; prev_valid blocks a bogus tick
    // on the first cycle out of reset.
    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            sec_q        <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            sec_q        <= bus.SECOND;
            prev_valid_q <= 1'b1;
        end
    end

    // Programmed alarm time (loaded only when legal) and snooze target.
    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
            snz_hour_q   <= '0;
            snz_min_q    <= '0;
        end else begin
            if (set_valid) begin
                alarm_hour_q <= bus.SET_HOUR;
                alarm_min_q  <= bus.SET_MINUTE;
            end
            if (snz_load) begin
                snz_hour_q <= snz_hour_calc;
                snz_min_q  <= snz_min_calc;
            end
        end
    end

    assign bus.RING         = ring_q;
    assign bus.STATE        = state_q;
    assign bus.ALARM_HOUR   = alarm_hour_q;
    assign bus.ALARM_MINUTE = alarm_min_q;
    assign bus.SET_ERR      = set_err_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: each step pushes the expected
// outputs, advances one clock and pops/compares against the DUT.
module tb_alarm_ctrl;
    import alarm_pkg::*;

    logic CLK_IN = 1'b0;
    logic RST_N;

    always #5 CLK_IN = ~CLK_IN;

    alarm_ctrl_if bus();

    alarm_ctrl #(
        .RING_SECONDS   (60),
        .SNOOZE_MINUTES (5)
    ) dut (
        .CLK_IN (CLK_IN),
        .RST_N  (RST_N),
        .bus    (bus)
    );

    typedef struct {
        string      tag;
        logic       ring;
        logic [1:0] state;
        logic [4:0] ah;
        logic [5:0] am;
        logic       err;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] exp_ah = 5'd0;
    logic [5:0] exp_am = 6'd0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        bus.HOUR   = 5'(h);
        bus.MINUTE = 6'(m);
        bus.SECOND = 6'(s);
    endtask

    // Push expectation, clock once, then pop and compare away from the edge.
    task automatic step(input string tag, input logic ring, input logic [1:0] st, input logic err);
        exp_t e;
        e.tag   = tag;
        e.ring  = ring;
        e.state = st;
        e.ah    = exp_ah;
        e.am    = exp_am;
        e.err   = err;
        sb_q.push_back(e);
        @(posedge CLK_IN);
        #1;
        if (sb_q.size() == 0) begin
            check_value({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            $display("[%0t] %s time=%0d:%0d:%0d ring=%0b state=%0d alarm=%0d:%0d err=%0b",
                     $time, e.tag, bus.HOUR, bus.MINUTE, bus.SECOND, bus.RING, bus.STATE,
                     bus.ALARM_HOUR, bus.ALARM_MINUTE, bus.SET_ERR);
            check_value({e.tag, "_ring"},  32'(bus.RING),         32'(e.ring));
            check_value({e.tag, "_state"}, 32'(bus.STATE),        32'(e.state));
            check_value({e.tag, "_ahour"}, 32'(bus.ALARM_HOUR),   32'(e.ah));
            check_value({e.tag, "_amin"},  32'(bus.ALARM_MINUTE), 32'(e.am));
            check_value({e.tag, "_err"},   32'(bus.SET_ERR),      32'(e.err));
        end
    endtask

    initial begin
        RST_N          = 1'b0;
        bus.ARM        = 1'b0;
        bus.SET_EN     = 1'b0;
        bus.SET_HOUR   = '0;
        bus.SET_MINUTE = '0;
        bus.STOP       = 1'b0;
        bus.SNOOZE     = 1'b0;
        set_time(7, 29, 50);

        // Reset state
        step("reset", 0, ST_IDLE, 0);
        RST_N   = 1'b1;
        bus.ARM = 1'b1;
        step("arm", 0, ST_ARMED, 0);

        // Program 07:30
        bus.SET_EN = 1'b1; bus.SET_HOUR = 5'd7; bus.SET_MINUTE = 6'd30;
        exp_ah = 5'd7; exp_am = 6'd30;
        step("set_0730", 0, ST_ARMED, 0);
        bus.SET_EN = 1'b0;

        // Reach alarm time and ring
        set_time(7, 29, 59);
        step("pre_alarm", 0, ST_ARMED, 0);
        set_time(7, 30, 0);
        step("alarm_hit", 1, ST_RINGING, 0);

        // Timeout after 60 ticks; extra idle clocks must not count
        for (int i = 1; i <= 60; i++) begin
            set_time(7, 30 + i / 60, i % 60);
            if (i < 60) step("ring_tick", 1, ST_RINGING, 0);
            else        step("ring_timeout", 0, ST_ARMED, 0);
            if (i == 59) repeat (5) step("ring_hold", 1, ST_RINGING, 0);
        end

        // STOP while ringing, then frozen time must not re-ring
        set_time(7, 29, 59);
        step("pre_alarm2", 0, ST_ARMED, 0);
        set_time(7, 30, 0);
        step("alarm_hit2", 1, ST_RINGING, 0);
        bus.STOP = 1'b1;
        step("stop", 0, ST_ARMED, 0);
        bus.STOP = 1'b0;
        repeat (100) step("static_time", 0, ST_ARMED, 0);

        // Snooze across the day boundary: 23:58 + 5 -> 00:03
        bus.SET_EN = 1'b1; bus.SET_HOUR = 5'd23; bus.SET_MINUTE = 6'd58;
        exp_ah = 5'd23; exp_am = 6'd58;
        step("set_2358", 0, ST_ARMED, 0);
        bus.SET_EN = 1'b0;
        set_time(23, 57, 59);
        step("pre_2358", 0, ST_ARMED, 0);
        set_time(23, 58, 0);
        step("alarm_2358", 1, ST_RINGING, 0);
        bus.SNOOZE = 1'b1;
        step("snooze", 0, ST_SNOOZED, 0);
        bus.SNOOZE = 1'b0;
        set_time(23, 59, 59);
        step("snz_wait1", 0, ST_SNOOZED, 0);
        set_time(0, 0, 0);
        step("snz_midnight", 0, ST_SNOOZED, 0);
        set_time(0, 2, 59);
        step("snz_wait2", 0, ST_SNOOZED, 0);
        set_time(0, 3, 0);
        step("snz_fire", 1, ST_RINGING, 0);

        // Valid SET_EN while ringing returns to ARMED
        bus.SET_EN = 1'b1; bus.SET_HOUR = 5'd7; bus.SET_MINUTE = 6'd30;
        exp_ah = 5'd7; exp_am = 6'd30;
        step("set_in_ring", 0, ST_ARMED, 0);

        // Invalid SET_EN: error pulse, alarm time held
        bus.SET_HOUR = 5'd24; bus.SET_MINUTE = 6'd10;
        step("set_bad_hour", 0, ST_ARMED, 1);
        bus.SET_EN = 1'b0;
        step("err_clear", 0, ST_ARMED, 0);
        bus.SET_EN = 1'b1; bus.SET_HOUR = 5'd5; bus.SET_MINUTE = 6'd60;
        step("set_bad_min", 0, ST_ARMED, 1);
        bus.SET_EN = 1'b0;
        step("err_clear2", 0, ST_ARMED, 0);

        // Coincident !ARM, STOP and SNOOZE while ringing
        set_time(7, 29, 59);
        step("pre_alarm3", 0, ST_ARMED, 0);
        set_time(7, 30, 0);
        step("alarm_hit3", 1, ST_RINGING, 0);
        bus.ARM = 1'b0; bus.STOP = 1'b1; bus.SNOOZE = 1'b1;
        step("disarm_all", 0, ST_IDLE, 0);
        bus.STOP = 1'b0; bus.SNOOZE = 1'b0;
        step("idle_hold", 0, ST_IDLE, 0);
        bus.ARM = 1'b1;
        step("rearm", 0, ST_ARMED, 0);

        // Reset in the middle of ringing
        set_time(7, 29, 59);
        step("pre_alarm4", 0, ST_ARMED, 0);
        set_time(7, 30, 0);
        step("alarm_hit4", 1, ST_RINGING, 0);
        RST_N = 1'b0;
        exp_ah = 5'd0; exp_am = 6'd0;
        step("reset_ring", 0, ST_IDLE, 0);
        RST_N = 1'b1;
        set_time(0, 0, 5);
        step("post_reset", 0, ST_ARMED, 0);

        if (sb_q.size() != 0) check_value("sb_leftover", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm controller sitting directly downstream of the calendar counter: it consumes the running SECOND/MINUTE/HOUR time, holds a user-programmed alarm time, and drives a RING output when that time is reached. Ringing stops on STOP, on timeout after RING_SECONDS, or on SNOOZE, which re-triggers SNOOZE_MINUTES later with wrap across hour and day. One clock domain shared with the calendar.

## Interface
- RING_SECONDS, 60, ring duration in second ticks before auto-stop (1..255)
- SNOOZE_MINUTES, 5, snooze offset in minutes (1..59)

- CLK_IN  in  1  clock, same as the calendar's
- RST_N  in  1  reset; one clock, synchronous, active-low
- SECOND  in  6  calendar seconds, 0..59
- MINUTE  in  6  calendar minutes, 0..59
- HOUR  in  5  calendar hours, 0..23
- ARM  in  1  level; 1 enables the alarm, 0 forces IDLE
- SET_EN  in  1  one-cycle pulse; load SET_HOUR/SET_MINUTE
- SET_HOUR  in  5  alarm hour to load
- SET_MINUTE  in  6  alarm minute to load
- STOP  in  1  one-cycle pulse; silence the alarm, no snooze
- SNOOZE  in  1  one-cycle pulse; silence and re-trigger later
- RING  out  1  alarm active
- ALARM_HOUR  out  5  programmed alarm hour
- ALARM_MINUTE  out  6  programmed alarm minute
- STATE  out  2  IDLE=0, ARMED=1, RINGING=2, SNOOZED=3
- SET_ERR  out  1  one-cycle pulse; rejected SET_EN

## Operation
- Second tick detection:
  - sec_q captures SECOND each cycle.
  - prev_valid is 0 at reset and 1 from the first cycle after reset.
  - tick = prev_valid & (SECOND != sec_q).
- match_alarm = tick & SECOND==0 & HOUR==ALARM_HOUR & MINUTE==ALARM_MINUTE.
- match_snooze = the same test against snz_hour/snz_min.
- Snooze target is captured on SNOOZE from the current HOUR:MINUTE:
  - snz_min = (MINUTE + SNOOZE_MINUTES) mod 60.
  - Carry into snz_hour = (HOUR + carry) mod 24.
  - Example: 23:58 + 5 gives 00:03.
- SET_EN validity: loads only if SET_HOUR<=23 and SET_MINUTE<=59. Otherwise the alarm registers hold and SET_ERR pulses.
- FSM transitions:
  - IDLE: ARM -> ARMED.
  - ARMED: match_alarm -> RINGING, ring_cnt cleared to 0.
  - RINGING, on each tick: ring_cnt increments; a tick with ring_cnt==RING_SECONDS-1 -> ARMED.
  - RINGING: STOP -> ARMED.
  - RINGING: SNOOZE -> SNOOZED, snooze target captured.
  - SNOOZED: match_snooze -> RINGING, ring_cnt cleared.
  - SNOOZED: STOP -> ARMED.
- Priority when events coincide: !ARM > valid SET_EN > STOP > SNOOZE > tick/match.
  - !ARM -> IDLE from any state.
  - A valid SET_EN in RINGING/SNOOZED -> ARMED. In ARMED it stays ARMED; in IDLE it stays IDLE.
- RING = (state == RINGING), registered.
- Alarm time persists through the IDLE/ARMED transitions; only reset clears it.

## Timing
- Reset values (cycle after RST_N sampled low):
  - RING=0, STATE=IDLE, SET_ERR=0.
  - ALARM_HOUR=0, ALARM_MINUTE=0.
  - ring_cnt=0, snz_hour=0, snz_min=0, prev_valid=0.
- Latency:
  - RING rises 1 cycle after the cycle in which SECOND changes to 0 at a matching HOUR:MINUTE.
  - STOP/SNOOZE/!ARM: RING falls 1 cycle after sampling.
  - ALARM_HOUR/ALARM_MINUTE update 1 cycle after a valid SET_EN.
  - SET_ERR is high exactly 1 cycle, 1 cycle after the invalid SET_EN.
- A match is evaluated only on a tick, so a static time never re-fires. After STOP at 07:00:xx, ARMED does not re-ring until the next day's 07:00:00.
- Reset mid-RINGING: RING=0 next cycle. No tick fires on the first post-reset cycle.
- If SECOND does not change for many cycles, ring_cnt holds; the timeout counts ticks, not clocks.

## Structure
- Package alarm_pkg:
  - state encoding IDLE/ARMED/RINGING/SNOOZED.
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - widths 6/6/5.
- Sub-module time_add_min: combinational HOUR:MINUTE + N minutes with mod-60/mod-24 wrap, used for the snooze target.
- Tick detector and FSM live in alarm_ctrl.

## Test plan
- Reset, ARM=1, set 07:30, drive time 07:29:59 -> 07:30:00:
  - RING=1 one cycle later, STATE=2.
  - After 60 further ticks, RING=0 and STATE=1.
- Ringing at 23:58:00, pulse SNOOZE:
  - RING=0, STATE=3.
  - Drive 00:03:00 -> RING=1 (day wrap).
- STOP while ringing: RING=0, STATE=1. Holding time at 07:30:00 for 100 cycles gives no re-ring.
- SET_EN with SET_HOUR=24, SET_MINUTE=10:
  - SET_ERR pulse for 1 cycle.
  - ALARM_HOUR/ALARM_MINUTE unchanged at 07:30.
- Same cycle ARM 1->0, STOP and SNOOZE while ringing -> STATE=0, RING=0, snooze target not captured.
- RST_N low for 1 cycle while ringing:
  - All outputs at reset values next cycle.
  - No tick on the following cycle even if SECOND != 0.
